// File: rtl/led_blink_sched.sv
// led_blink_sched: status-LED scheduler for the board debug LED.
// Arbitrates four requesters and plays the winner's blink code as N pulses
// followed by a long gap, repeating. When nothing is pending the LED shows a
// heartbeat. Arbitration happens only in IDLE and at the end of GAP, so a
// code that has started always plays to completion.
module led_blink_sched #(
  parameter int unsigned TICK_DIV = 25000,
  parameter int unsigned T_ON     = 200,
  parameter int unsigned T_OFF    = 200,
  parameter int unsigned T_GAP    = 1000,
  parameter int unsigned T_HB     = 1000
) (
  input  logic       I_clk,
  input  logic       I_reset_n,
  input  logic [3:0] I_req,
  input  logic [3:0] I_code0,
  input  logic [3:0] I_code1,
  input  logic [3:0] I_code2,
  input  logic [3:0] I_code3,
  input  logic       I_force_off,
  output logic       O_led,
  output logic       O_busy,
  output logic [1:0] O_active_id
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned ID_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ON    = 3'd2,
    S_OFF   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [CODE_W-1:0]   pulse_q, pulse_d;
  logic                led_q, led_d;
  logic [ID_W-1:0]     id_d;

  logic [3:0]          valid_c;
  logic                any_valid_c;
  logic [ID_W-1:0]     win_id_c;
  logic [CODE_W-1:0]   win_code_c;
  logic                tick_c;
  logic                on_done_c;
  logic                off_done_c;
  logic                gap_done_c;
  logic                hb_done_c;

  // A requester only counts when it is flagged and carries a nonzero code
  assign valid_c[0]  = I_req[0] & (I_code0 != 4'd0);
  assign valid_c[1]  = I_req[1] & (I_code1 != 4'd0);
  assign valid_c[2]  = I_req[2] & (I_code2 != 4'd0);
  assign valid_c[3]  = I_req[3] & (I_code3 != 4'd0);
  assign any_valid_c = |valid_c;

  // Fixed priority: lowest valid index wins
  always_comb begin
    win_id_c   = 2'd0;
    win_code_c = I_code0;
    if (valid_c[0]) begin
      win_id_c   = 2'd0;
      win_code_c = I_code0;
    end else if (valid_c[1]) begin
      win_id_c   = 2'd1;
      win_code_c = I_code1;
    end else if (valid_c[2]) begin
      win_id_c   = 2'd2;
      win_code_c = I_code2;
    end else if (valid_c[3]) begin
      win_id_c   = 2'd3;
      win_code_c = I_code3;
    end
  end

  // Timebase tick and per-state duration terminals (the T-th tick ends a state)
  assign tick_c     = (presc_q == CNT_W'(TICK_DIV - 1));
  assign on_done_c  = tick_c && (tick_cnt_q == CNT_W'(T_ON - 1));
  assign off_done_c = tick_c && (tick_cnt_q == CNT_W'(T_OFF - 1));
  assign gap_done_c = tick_c && (tick_cnt_q == CNT_W'(T_GAP - 1));
  assign hb_done_c  = tick_c && (tick_cnt_q == CNT_W'(T_HB - 1));

  // Next-state, counter and LED computation
  always_comb begin
    state_d    = state_q;
    presc_d    = tick_c ? '0 : presc_q + CNT_W'(1);
    tick_cnt_d = tick_c ? tick_cnt_q + CNT_W'(1) : tick_cnt_q;
    pulse_d    = pulse_q;
    led_d      = led_q;
    id_d       = O_active_id;

    unique case (state_q)
      S_IDLE: begin
        if (any_valid_c) begin
          state_d = S_LATCH;
          id_d    = win_id_c;
          pulse_d = win_code_c;
        end else if (hb_done_c) begin
          led_d      = ~led_q;
          tick_cnt_d = '0;
        end
      end
      S_LATCH: begin
        state_d = S_ON;
      end
      S_ON: begin
        if (on_done_c) begin
          pulse_d = pulse_q - CODE_W'(1);
          state_d = S_OFF;
        end
      end
      S_OFF: begin
        if (off_done_c) begin
          state_d = (pulse_q != '0) ? S_ON : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_done_c) begin
          if (any_valid_c) begin
            state_d = S_LATCH;
            id_d    = win_id_c;
            pulse_d = win_code_c;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every transition restarts the timebase; the LED is lit only in ON
    if (state_d != state_q) begin
      presc_d    = '0;
      tick_cnt_d = '0;
      led_d      = (state_d == S_ON);
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      tick_cnt_q  <= '0;
      pulse_q     <= '0;
      led_q       <= 1'b0;
      O_led       <= 1'b0;
      O_busy      <= 1'b0;
      O_active_id <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_cnt_q  <= tick_cnt_d;
      pulse_q     <= pulse_d;
      led_q       <= led_d;
      O_led       <= led_d & ~I_force_off;
      O_busy      <= (state_d != S_IDLE);
      O_active_id <= id_d;
    end
  end

endmodule

// File: tb/tb_led_blink_sched.sv
// tb_led_blink_sched: directed stimulus for led_blink_sched with a
// waveform-level reference model and per-cycle output comparison.
module tb_led_blink_sched;

  localparam int TICK_DIV = 4;
  localparam int T_ON     = 2;
  localparam int T_OFF    = 3;
  localparam int T_GAP    = 5;
  localparam int T_HB     = 6;

  logic       I_clk = 1'b0;
  logic       I_reset_n = 1'b1;
  logic [3:0] I_req = 4'd0;
  logic [3:0] I_code0 = 4'd0;
  logic [3:0] I_code1 = 4'd0;
  logic [3:0] I_code2 = 4'd0;
  logic [3:0] I_code3 = 4'd0;
  logic       I_force_off = 1'b0;
  logic       O_led;
  logic       O_busy;
  logic [1:0] O_active_id;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Reference model state: expected outputs after the latest clock edge
  bit         seq_q[$];
  int         idle_cnt = 0;
  logic       m_led = 1'b0;
  logic       m_busy = 1'b0;
  logic [1:0] m_id = 2'd0;

  led_blink_sched #(
    .TICK_DIV(TICK_DIV),
    .T_ON    (T_ON),
    .T_OFF   (T_OFF),
    .T_GAP   (T_GAP),
    .T_HB    (T_HB)
  ) dut (
    .I_clk      (I_clk),
    .I_reset_n  (I_reset_n),
    .I_req      (I_req),
    .I_code0    (I_code0),
    .I_code1    (I_code1),
    .I_code2    (I_code2),
    .I_code3    (I_code3),
    .I_force_off(I_force_off),
    .O_led      (O_led),
    .O_busy     (O_busy),
    .O_active_id(O_active_id)
  );

  // 25 MHz clock
  always #20 I_clk = ~I_clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] code_of(input int i);
    case (i)
      0:       return I_code0;
      1:       return I_code1;
      2:       return I_code2;
      default: return I_code3;
    endcase
  endfunction

  // Model: at an arbitration point the whole code is expanded into a per-clock
  // LED waveform (LATCH, N x (ON, OFF), GAP); otherwise the heartbeat is a
  // square wave measured from the moment IDLE was entered.
  task automatic model_step();
    int w;
    bit raw;
    if (!I_reset_n) begin
      seq_q.delete();
      idle_cnt = 0;
      m_busy   = 1'b0;
      m_id     = 2'd0;
      m_led    = 1'b0;
    end else begin
      if (seq_q.size() == 0) begin
        w = -1;
        for (int i = 3; i >= 0; i--) begin
          if (I_req[i] && code_of(i) != 4'd0) w = i;
        end
        if (w >= 0) begin
          m_id = 2'(w);
          seq_q.push_back(1'b0);
          for (int p = 0; p < int'(code_of(w)); p++) begin
            for (int c = 0; c < T_ON * TICK_DIV; c++) seq_q.push_back(1'b1);
            for (int c = 0; c < T_OFF * TICK_DIV; c++) seq_q.push_back(1'b0);
          end
          for (int c = 0; c < T_GAP * TICK_DIV; c++) seq_q.push_back(1'b0);
        end else if (m_busy) begin
          idle_cnt = 0;
        end else begin
          idle_cnt++;
        end
      end
      if (seq_q.size() != 0) begin
        raw    = seq_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
        raw    = ((idle_cnt / (T_HB * TICK_DIV)) % 2) == 1;
      end
      m_led = raw & ~I_force_off;
    end
  endtask

  initial begin
    forever begin
      @(posedge I_clk or negedge I_reset_n);
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge I_clk) begin
    if (cmp_en) begin
      check("cyc_led", {3'b0, O_led}, {3'b0, m_led});
      check("cyc_busy", {3'b0, O_busy}, {3'b0, m_busy});
      check("cyc_id", {2'b0, O_active_id}, {2'b0, m_id});
    end
  end

  task automatic wait_idle(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge I_clk);
      if (O_busy === 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: O_busy still high after %0d clocks", name, budget);
    end
  endtask

  task automatic check_heartbeat(input string name);
    repeat (23) @(negedge I_clk);
    check({name, "_t23"}, {3'b0, O_led}, 4'd0);
    @(negedge I_clk);
    check({name, "_t24"}, {3'b0, O_led}, 4'd1);
  endtask

  initial begin
    // Reset
    #1 I_reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    check("rst_led", {3'b0, O_led}, 4'd0);
    check("rst_busy", {3'b0, O_busy}, 4'd0);
    check("rst_id", {2'b0, O_active_id}, 4'd0);
    repeat (3) @(negedge I_clk);
    I_reset_n = 1'b1;

    // 1. Heartbeat: toggles every 24 clocks starting low
    check_heartbeat("hb");
    check("hb_busy", {3'b0, O_busy}, 4'd0);
    repeat (24) @(negedge I_clk);
    check("hb_t48", {3'b0, O_led}, 4'd0);

    // 2. Single code 3 on requester 0
    I_code0 = 4'd3;
    I_req   = 4'b0001;
    @(negedge I_clk);
    check("sc_latch_led", {3'b0, O_led}, 4'd0);
    check("sc_latch_busy", {3'b0, O_busy}, 4'd1);
    check("sc_latch_id", {2'b0, O_active_id}, 4'd0);
    @(negedge I_clk);
    check("sc_on_first", {3'b0, O_led}, 4'd1);
    repeat (7) @(negedge I_clk);
    check("sc_on_last", {3'b0, O_led}, 4'd1);
    @(negedge I_clk);
    check("sc_off_first", {3'b0, O_led}, 4'd0);
    repeat (11) @(negedge I_clk);
    check("sc_off_last", {3'b0, O_led}, 4'd0);
    @(negedge I_clk);
    check("sc_on2_first", {3'b0, O_led}, 4'd1);
    repeat (60) @(negedge I_clk);
    check("sc_relatch_led", {3'b0, O_led}, 4'd0);
    check("sc_relatch_busy", {3'b0, O_busy}, 4'd1);
    @(negedge I_clk);
    check("sc_reon", {3'b0, O_led}, 4'd1);
    I_req = 4'b0000;
    wait_idle(200, "sc_idle");

    // 3. Priority without pre-emption
    I_code2 = 4'd2;
    I_req   = 4'b0100;
    @(negedge I_clk);
    check("pr_id2", {2'b0, O_active_id}, 4'd2);
    @(negedge I_clk);
    I_code1 = 4'd1;
    I_req   = 4'b0110;
    repeat (59) @(negedge I_clk);
    check("pr_gap_id", {2'b0, O_active_id}, 4'd2);
    check("pr_gap_led", {3'b0, O_led}, 4'd0);
    @(negedge I_clk);
    check("pr_id1", {2'b0, O_active_id}, 4'd1);
    check("pr_latch_busy", {3'b0, O_busy}, 4'd1);
    I_req = 4'b0000;
    @(negedge I_clk);
    check("pr_on", {3'b0, O_led}, 4'd1);
    wait_idle(200, "pr_idle");

    // 4. Code zero is ignored; dropped request still completes
    I_code3 = 4'd0;
    I_req   = 4'b1000;
    repeat (30) @(negedge I_clk);
    check("cz_busy", {3'b0, O_busy}, 4'd0);
    I_code3 = 4'd4;
    @(negedge I_clk);
    check("cz_latch_id", {2'b0, O_active_id}, 4'd3);
    repeat (21) @(negedge I_clk);
    I_req = 4'b0000;
    wait_idle(400, "drop_idle");
    check("drop_hb_t0", {3'b0, O_led}, 4'd0);
    check("drop_id_hold", {2'b0, O_active_id}, 4'd3);
    check_heartbeat("drop_hb");

    // 5. Force-off masks the LED with one clock latency
    I_code0 = 4'd2;
    I_req   = 4'b0001;
    @(negedge I_clk);
    @(negedge I_clk);
    check("fo_on", {3'b0, O_led}, 4'd1);
    I_force_off = 1'b1;
    @(negedge I_clk);
    check("fo_masked", {3'b0, O_led}, 4'd0);
    check("fo_busy", {3'b0, O_busy}, 4'd1);
    I_force_off = 1'b0;
    @(negedge I_clk);
    check("fo_unmasked", {3'b0, O_led}, 4'd1);
    repeat (5) @(negedge I_clk);
    check("fo_on_last", {3'b0, O_led}, 4'd1);
    @(negedge I_clk);
    check("fo_off", {3'b0, O_led}, 4'd0);
    I_req = 4'b0000;
    wait_idle(200, "fo_idle");

    // 6. Asynchronous reset during OFF of a code-15 sequence
    I_code0 = 4'd15;
    I_req   = 4'b0001;
    repeat (12) @(negedge I_clk);
    check("ar_off_busy", {3'b0, O_busy}, 4'd1);
    #5;
    I_reset_n = 1'b0;
    I_req     = 4'b0000;
    #1;
    check("ar_led", {3'b0, O_led}, 4'd0);
    check("ar_busy", {3'b0, O_busy}, 4'd0);
    check("ar_id", {2'b0, O_active_id}, 4'd0);
    @(negedge I_clk);
    @(negedge I_clk);
    I_reset_n = 1'b1;
    check_heartbeat("ar_hb");

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_blink_sched.md
Name: led_blink_sched

Overview:
- Status-LED scheduler for the board debug LED.
- Arbitrates four status requesters and plays the winner's blink code on one LED: N pulses, then a long gap, then repeat.
- Shows a 1 s heartbeat toggle when no requester is pending.
- Sits between the fault/status sources and the LED pin.
- Runs from the 25 MHz system clock.

Parameters:
- TICK_DIV, 25000: clocks per timebase tick (1 ms at 25 MHz); range 2..65535.
- T_ON, 200: ticks the LED is lit per pulse; range 1..65535.
- T_OFF, 200: ticks the LED is dark between pulses; range 1..65535.
- T_GAP, 1000: ticks the LED is dark after the last pulse of a code; range 1..65535.
- T_HB, 1000: ticks per heartbeat half-period in IDLE; range 1..65535.

Ports:
- I_clk  input  1  system clock, 25 MHz.
- I_reset_n  input  1  reset, asynchronous, active-low.
- I_req  input  4  per-requester pending flag; bit 0 has the highest priority.
- I_code0  input  4  blink count for requester 0; value 0 means no request.
- I_code1  input  4  blink count for requester 1.
- I_code2  input  4  blink count for requester 2.
- I_code3  input  4  blink count for requester 3.
- I_force_off  input  1  synchronous LED mask.
- O_led  output  1  LED drive, registered, 1 = lit.
- O_busy  output  1  high in every state except IDLE.
- O_active_id  output  2  index of the requester whose code is playing.

Behaviour:
- Reset (I_reset_n = 0, asynchronous):
  - state = IDLE; O_led = 0; O_busy = 0; O_active_id = 0.
  - All counters cleared.
- Valid requester: bit i is valid when I_req[i] = 1 and I_code_i != 0.
- Winner: the lowest-index valid requester.
- Prescaler:
  - Counts 0..TICK_DIV-1 and emits a one-cycle tick on wrap.
  - Cleared on every state transition, so a state with duration T lasts exactly T*TICK_DIV clocks.
- Tick counter (16 bit): increments on tick; cleared on every state transition.
- Pulse counter (4 bit): loaded with the latched code in LATCH.
- States and transitions:
  - IDLE:
    - Heartbeat: the LED register toggles each time the tick counter reaches T_HB, then the tick counter clears.
    - Entering IDLE forces the LED register to 0 and restarts the heartbeat.
    - Any valid requester -> LATCH on the next clock.
  - LATCH (1 clock):
    - Latches the winner index into O_active_id and its code into the pulse counter.
    - LED register = 0.
    - -> ON.
  - ON:
    - LED register = 1 for T_ON ticks.
    - Then decrement the pulse counter -> OFF.
  - OFF:
    - LED register = 0 for T_OFF ticks.
    - Then, if pulse counter != 0 -> ON, else -> GAP.
  - GAP:
    - LED register = 0 for T_GAP ticks.
    - Then re-arbitrate using current inputs: any valid requester -> LATCH, else -> IDLE.
- Arbitration is sampled only in IDLE and at the end of GAP. A sequence in progress is never pre-empted or truncated.
- Input changes mid-sequence:
  - Deasserting or changing I_req / I_code mid-sequence has no effect until the next arbitration point.
  - A higher-priority request raised mid-sequence waits for the end of GAP.
- O_led = LED register AND NOT I_force_off, registered: the mask takes effect one clock after I_force_off changes. The state machine and counters keep running while masked.
- O_busy and O_active_id are registered and update on the same edge as the state register. O_active_id holds its last value in IDLE.
- Code 15 is the maximum: 15 pulses.
- All timers saturate-free: each parameter is compared with ==, and each counter clears on the transition.
- Reset asserted mid-sequence returns to IDLE immediately. No pending state is retained.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, T_ON=2, T_OFF=3, T_GAP=5, T_HB=6.
1. Heartbeat: release reset with no requests -> O_led toggles every 24 clocks, starting at 0; O_busy stays 0.
2. Single code: I_req=0001, I_code0=3 -> 1 clock LATCH, then three 8-clock high pulses separated by 12-clock lows, then a 20-clock GAP, then repeat; O_active_id=0, O_busy=1.
3. Priority and non-pre-emption:
   - Start requester 2 with code 2; raise requester 1 with code 1 during the first ON.
   - -> the 2-pulse sequence completes, then after GAP O_active_id=1 and one pulse plays.
4. Code-zero and drop:
   - I_req=1000 with I_code3=0 -> remains IDLE.
   - A request with code 4 dropped after the first pulse -> all 4 pulses play, then GAP -> IDLE with heartbeat restarting from LED=0.
5. Force-off: assert I_force_off during ON -> O_led = 0 from the next clock; on deassert mid-ON, O_led = 1 the next clock, with pulse timing unchanged.
6. Async reset pulse during OFF with code 15 -> O_led=0, O_busy=0 immediately; after release, IDLE heartbeat restarts.
